// File: rtl/fetch_pc_unit_if.sv
// Fetch/PC stage bus: instruction memory, decoder hand-off, decoder
// controls, accelerator arbitration and status. The master modport is the
// fetch unit; the slave modport is memory, decoder and accelerator.
// fsm_state exposes the fetch FSM encoding for observation.
interface fetch_pc_unit_if #(
   parameter int unsigned PC_W = 16
);
   logic [PC_W-1:0] imem_addr;
   logic [15:0]     imem_data;
   logic [15:0]     instr;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_plus1;
   logic            PC_src;
   logic            Jmp;
   logic            Jalr;
   logic            Jr;
   logic            Hlt;
   logic [15:0]     rd_data;
   logic            acc_busy;
   logic            acc_start;
   logic            stalled;
   logic            halted;
   logic [31:0]     retire_cnt;
   logic [1:0]      fsm_state;

   modport master (
      output imem_addr, instr, pc, pc_plus1, acc_start, stalled, halted,
             retire_cnt, fsm_state,
      input  imem_data, PC_src, Jmp, Jalr, Jr, Hlt, rd_data, acc_busy
   );

   modport slave (
      input  imem_addr, instr, pc, pc_plus1, acc_start, stalled, halted,
             retire_cnt, fsm_state,
      output imem_data, PC_src, Jmp, Jalr, Jr, Hlt, rd_data, acc_busy
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction fetch and program counter for the single-cycle core.
// Fetch-to-decode is combinational: the word at imem_addr issues in the
// same cycle unless the core is stalled on the accelerator or halted.
// MVM (11111) and DIC (11110) are held while the accelerator is busy; an
// MVM that issues raises acc_start for that single cycle.
// Handshake: an instruction is consumed (retired) on a rising edge exactly
// when issue is high; acc_start is a one-cycle launch with no ready return,
// and acc_busy acts as the accelerator's not-ready for MVM/DIC.
module fetch_pc_unit #(
   parameter int unsigned     PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter logic [15:0]     BUBBLE   = 16'h7800
) (
   input logic            clk,
   input logic            rst,
   fetch_pc_unit_if.master bus
);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_STALL = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   localparam logic [4:0] OP_DIC = 5'b11110;
   localparam logic [4:0] OP_MVM = 5'b11111;

   state_t          state;
   logic [PC_W-1:0] pc_q;
   logic [31:0]     retire_q;

   logic [4:0]      op;
   logic            hold;
   logic            issue;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] next_pc;

   // Offsets are sign-extended to the PC width so the add wraps modulo 2^PC_W.
   function automatic logic [PC_W-1:0] sext11(input logic [10:0] v);
      logic signed [31:0] ext;
      ext = 32'($signed(v));
      return ext[PC_W-1:0];
   endfunction

   function automatic logic [PC_W-1:0] sext8(input logic [7:0] v);
      logic signed [31:0] ext;
      ext = 32'($signed(v));
      return ext[PC_W-1:0];
   endfunction

   // Issue decision: accelerator ops wait for acc_busy low; hold is purely
   // combinational so a busy drop in the same cycle issues without a stall.
   always_comb begin
      op    = bus.imem_data[15:11];
      hold  = ((op == OP_DIC) || (op == OP_MVM)) && bus.acc_busy;
      issue = (state == S_RUN) && !rst && !hold;
   end

   // Next-PC selection for the issuing instruction; Hlt is handled in the FSM
   // and takes priority over every target here.
   always_comb begin
      pc_inc = pc_q + PC_W'(1);
      if (bus.Jr || bus.Jalr) begin
         next_pc = bus.rd_data[PC_W-1:0];
      end else if (bus.Jmp) begin
         next_pc = pc_inc + sext11(bus.imem_data[10:0]);
      end else if (bus.PC_src && (bus.imem_data[15:14] == 2'b10)) begin
         next_pc = pc_inc + sext11(bus.imem_data[10:0]);
      end else if (bus.PC_src) begin
         next_pc = pc_inc + sext8(bus.imem_data[7:0]);
      end else begin
         next_pc = pc_inc;
      end
   end

   // Fetch FSM with PC and retire counter; reset drops any pending MVM/DIC.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_RUN;
         pc_q     <= RESET_PC;
         retire_q <= '0;
      end else begin
         case (state)
            S_RUN: begin
               if (hold) begin
                  state <= S_STALL;
               end else begin
                  retire_q <= retire_q + 32'd1;
                  if (bus.Hlt) begin
                     state <= S_HALT;
                  end else begin
                     pc_q <= next_pc;
                  end
               end
            end
            S_STALL: begin
               if (!bus.acc_busy) begin
                  state <= S_RUN;
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_RUN;
            end
         endcase
      end
   end

   // Output drive.
   always_comb begin
      bus.imem_addr  = pc_q;
      bus.pc         = pc_q;
      bus.pc_plus1   = pc_inc;
      bus.instr      = issue ? bus.imem_data : BUBBLE;
      bus.acc_start  = issue && (op == OP_MVM);
      bus.stalled    = !rst && ((state == S_STALL) || ((state == S_RUN) && hold));
      bus.halted     = (state == S_HALT) && !rst;
      bus.retire_cnt = retire_q;
      bus.fsm_state  = state;
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed test-plan steps followed by random
// cycles, every cycle compared against a behavioural model of the stage.
module tb_fetch_pc_unit;

   localparam logic [15:0] BUBBLE = 16'h7800;

   logic clk;
   logic rst;
   fetch_pc_unit_if #(.PC_W(16)) bus ();

   fetch_pc_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;
   int start_pulses = 0;

   // Behavioural model state
   logic [15:0] m_pc;
   logic [31:0] m_ret;
   logic        m_halted;
   logic        m_waiting;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic [15:0] d, input logic src, input logic jmp,
                         input logic jalr, input logic jr, input logic hlt,
                         input logic [15:0] rd, input logic busy);
      bus.imem_data = d;
      bus.PC_src    = src;
      bus.Jmp       = jmp;
      bus.Jalr      = jalr;
      bus.Jr        = jr;
      bus.Hlt       = hlt;
      bus.rd_data   = rd;
      bus.acc_busy  = busy;
   endtask

   // One cycle: check all outputs against the model mid-cycle, then clock
   // and advance the model using the same inputs.
   task automatic step();
      logic [15:0] d;
      logic [4:0]  op;
      logic [10:0] f11;
      logic [7:0]  f8;
      int          off;
      bit          acc_op, hold, issue;
      #1;
      d      = bus.imem_data;
      op     = d[15:11];
      acc_op = (op == 5'd30) || (op == 5'd31);
      hold   = acc_op && bus.acc_busy;
      issue  = !m_halted && !m_waiting && !rst && !hold;
      chk("pc",         {16'h0, bus.pc},        {16'h0, m_pc});
      chk("imem_addr",  {16'h0, bus.imem_addr}, {16'h0, m_pc});
      chk("pc_plus1",   {16'h0, bus.pc_plus1},  {16'h0, 16'(m_pc + 16'd1)});
      chk("instr",      {16'h0, bus.instr},     {16'h0, issue ? d : BUBBLE});
      chk("acc_start",  {31'h0, bus.acc_start}, {31'h0, issue && (op == 5'd31)});
      chk("stalled",    {31'h0, bus.stalled},   {31'h0, !rst && (m_waiting || (!m_halted && hold))});
      chk("halted",     {31'h0, bus.halted},    {31'h0, m_halted && !rst});
      chk("retire_cnt", bus.retire_cnt,         m_ret);
      if (bus.acc_start === 1'b1) start_pulses++;
      @(posedge clk);
      if (rst) begin
         m_pc = 16'h0000; m_ret = 0; m_halted = 0; m_waiting = 0;
      end else if (m_waiting) begin
         if (!bus.acc_busy) m_waiting = 0;
      end else if (!m_halted) begin
         if (hold) begin
            m_waiting = 1;
         end else begin
            m_ret = m_ret + 32'd1;
            f11 = d[10:0];
            f8  = d[7:0];
            if (bus.Hlt) m_halted = 1;
            else if (bus.Jr || bus.Jalr) m_pc = bus.rd_data;
            else if (bus.Jmp) begin
               off = $signed(f11); m_pc = 16'(int'(m_pc) + 1 + off);
            end else if (bus.PC_src) begin
               if (d[15:14] == 2'b10) off = $signed(f11);
               else off = $signed(f8);
               m_pc = 16'(int'(m_pc) + 1 + off);
            end else m_pc = m_pc + 16'd1;
         end
      end
      #1;
   endtask

   // Jump to an address through Jr so directed tests start at fixed PCs.
   task automatic goto_pc(input logic [15:0] a);
      set_in(16'h0000, 0, 0, 0, 1, 0, a, 0);
      step();
      chk("goto_pc", {16'h0, bus.pc}, {16'h0, a});
   endtask

   logic [31:0] saved_ret;
   int          pulses_before;

   initial begin
      rst = 1'b1;
      set_in(BUBBLE, 0, 0, 0, 0, 0, 16'h0, 0);
      @(posedge clk);
      #1;
      m_pc = 16'h0000; m_ret = 0; m_halted = 0; m_waiting = 0;

      // Reset cycle
      step();
      chk("reset_pc", {16'h0, bus.pc}, 32'h0);
      chk("reset_ret", bus.retire_cnt, 32'h0);
      rst = 1'b0;

      // Sequential fetch of ALU ops at 0..3
      for (int i = 0; i < 4; i++) begin
         set_in(16'h0123 + 16'(i), 0, 0, 0, 0, 0, 16'h0, 0);
         chk("seq_pc", {16'h0, bus.pc}, 32'(i));
         step();
      end
      chk("seq_ret4", bus.retire_cnt, 32'd4);

      // BRN taken at 0x0010 with offset 0xFE
      goto_pc(16'h0010);
      set_in(16'h60FE, 1, 0, 0, 0, 0, 16'h0, 0);
      step();
      chk("brn_pc", {16'h0, bus.pc}, 32'h000F);

      // JAL at 0x0010 with offset 0x020
      goto_pc(16'h0010);
      set_in(16'h8020, 1, 0, 0, 0, 0, 16'h0, 0);
      #1;
      chk("jal_link", {16'h0, bus.pc_plus1}, 32'h0011);
      step();
      chk("jal_pc", {16'h0, bus.pc}, 32'h0031);

      // Jr to 0x0100
      set_in(16'h0000, 0, 0, 0, 1, 0, 16'h0100, 0);
      step();
      chk("jr_pc", {16'h0, bus.pc}, 32'h0100);

      // MVM with idle accelerator: one pulse, PC advances
      pulses_before = start_pulses;
      set_in(16'hF800, 0, 0, 0, 0, 0, 16'h0, 0);
      step();
      chk("mvm_pc", {16'h0, bus.pc}, 32'h0101);
      set_in(16'h0001, 0, 0, 0, 0, 0, 16'h0, 0);
      step();
      chk("mvm_pulses", 32'(start_pulses - pulses_before), 32'd1);

      // DIC with busy for 3 cycles: 4 stall cycles, issues in cycle 5
      for (int i = 0; i < 4; i++) begin
         set_in(16'hF000, 0, 0, 0, 0, 0, 16'h0, (i < 3));
         #1;
         chk("dic_stalled", {31'h0, bus.stalled}, 32'd1);
         chk("dic_bubble", {16'h0, bus.instr}, {16'h0, BUBBLE});
         step();
         chk("dic_pc_frozen", {16'h0, bus.pc}, 32'h0102);
      end
      #1;
      chk("dic_issue", {16'h0, bus.instr}, 32'hF000);
      chk("dic_issue_nostall", {31'h0, bus.stalled}, 32'd0);
      step();

      // MVM while busy for 2 cycles: 3 stalls, then one pulse only
      pulses_before = start_pulses;
      for (int i = 0; i < 3; i++) begin
         set_in(16'hF805, 0, 0, 0, 0, 0, 16'h0, (i < 2));
         #1;
         chk("mvmb_stalled", {31'h0, bus.stalled}, 32'd1);
         step();
      end
      #1;
      chk("mvmb_start", {31'h0, bus.acc_start}, 32'd1);
      step();
      set_in(16'h0002, 0, 0, 0, 0, 0, 16'h0, 0);
      step();
      chk("mvmb_pulses", 32'(start_pulses - pulses_before), 32'd1);

      // OUT-halt at 0x0020; Jr asserted too, Hlt must win
      goto_pc(16'h0020);
      set_in(16'h7001, 0, 0, 0, 1, 1, 16'h0300, 0);
      step();
      saved_ret = m_ret;
      for (int i = 0; i < 3; i++) begin
         set_in(16'hF800, 1, 1, 0, 0, 0, 16'h0, 0);
         step();
         chk("halt_flag", {31'h0, bus.halted}, 32'd1);
         chk("halt_pc", {16'h0, bus.pc}, 32'h0020);
         chk("halt_ret", bus.retire_cnt, saved_ret);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("unhalt_pc", {16'h0, bus.pc}, 32'h0);
      chk("unhalt_flag", {31'h0, bus.halted}, 32'd0);

      // Wrap from 0xFFFF
      goto_pc(16'hFFFF);
      set_in(16'h0003, 0, 0, 0, 0, 0, 16'h0, 0);
      step();
      chk("wrap_pc", {16'h0, bus.pc}, 32'h0000);

      // Reset during a stall drops the pending MVM
      set_in(16'hF800, 0, 0, 0, 0, 0, 16'h0, 1);
      step();
      step();
      pulses_before = start_pulses;
      rst = 1'b1;
      #1;
      chk("rststall_stalled", {31'h0, bus.stalled}, 32'd0);
      chk("rststall_start", {31'h0, bus.acc_start}, 32'd0);
      step();
      rst = 1'b0;
      set_in(16'h0004, 0, 0, 0, 0, 0, 16'h0, 0);
      step();
      chk("rststall_pulses", 32'(start_pulses - pulses_before), 32'd0);
      chk("rststall_pc", {16'h0, bus.pc}, 32'h0001);

      // Random cycles against the model
      for (int n = 0; n < 400; n++) begin
         logic [15:0] d;
         d = 16'($urandom);
         if ($urandom_range(0, 3) == 0) d[15:12] = 4'hF;
         set_in(d,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 29) == 0), 16'($urandom),
                ($urandom_range(0, 1) == 0));
         rst = ($urandom_range(0, 39) == 0);
         step();
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
